spi_xfer_sched: RTL and testbench

Round-robin transaction scheduler that shares one byte-level SPI master engine (start/busy/d_out/d_in handshake) among N_REQ requesters. It grants the engine to one requester at a time and issues that requester's bytes back-to-back until the burst's last byte completes. It returns each received byte to the owning requester and aborts on an engine that never goes busy. It sits between the system-side clients (sensor poller, flash loader, config writer) and the SPI master.

---
 rtl/spi_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/spi_xfer_sched.sv | 159 +++++++++++++++
 tb/tb_spi_xfer_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI types: scheduler states, default word width
// and the slice helper for flattened per-requester buses.
package spi_pkg;

  localparam int BUS_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or
// after ptr, wrapping modulo N_REQ; one-hot result.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Round-robin burst scheduler sharing one byte-level SPI
// master engine among N_REQ requesters.
module spi_xfer_sched
  import spi_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BUS_WIDTH-1:0] tx_data,
  input  logic [N_REQ-1:0]           tx_last,
  output logic [N_REQ-1:0]           tx_ack,
  output logic [N_REQ-1:0]           grant,
  output logic [BUS_WIDTH-1:0]       rx_data,
  output logic [N_REQ-1:0]           rx_valid,
  output logic [N_REQ-1:0]           rx_err,
  output logic                       spi_start,
  output logic [BUS_WIDTH-1:0]       spi_d_out,
  input  logic                       spi_busy,
  input  logic [BUS_WIDTH-1:0]       spi_d_in,
  output logic                       sched_busy
);

  localparam int PW = $clog2(N_REQ);

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic [BUS_WIDTH-1:0] dout_q, dout_d;
  logic [BUS_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [N_REQ-1:0]     rx_err_q, rx_err_d;

  logic [N_REQ-1:0]     arb_gnt;
  logic [PW-1:0]        arb_idx;
  logic [BUS_WIDTH-1:0] tx_sel;
  logic [PW-1:0]        ptr_next;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req(req),
    .ptr(rr_ptr_q),
    .gnt(arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    tx_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = PW'(i);
      if (owner_q == PW'(i)) begin
        tx_sel = tx_data[slice_lo(i, BUS_WIDTH) +: BUS_WIDTH];
      end
    end
  end

  assign ptr_next = (owner_q == PW'(N_REQ-1)) ?
                    '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    dout_d    = dout_q;
    rx_data_d = rx_data_q;
    rx_err_d  = '0;
    tx_ack    = '0;
    rx_valid  = '0;
    spi_start = 1'b0;
    spi_d_out = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = arb_idx;
          grant_d = arb_gnt;
          state_d = S_START;
        end
      end
      S_START: begin
        spi_start = 1'b1;
        spi_d_out = tx_sel;
        dout_d    = tx_sel;
        tx_ack    = grant_q;
        last_d    = tx_last[owner_q];
        cnt_d     = '0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          // abort drops the rest of the burst
          rx_err_d = grant_q;
          grant_d  = '0;
          rr_ptr_d = ptr_next;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!spi_busy) begin
          rx_data_d = spi_d_in;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        rx_valid = grant_q;
        if (last_q || !req[owner_q]) begin
          grant_d  = '0;
          rr_ptr_d = ptr_next;
          state_d  = S_IDLE;
        end else begin
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      dout_q    <= '0;
      rx_data_q <= '0;
      rx_err_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      dout_q    <= dout_d;
      rx_data_q <= rx_data_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign grant      = grant_q;
  assign rx_data    = rx_data_q;
  assign rx_err     = rx_err_q;
  assign sched_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with a loopback engine
// model and scoreboards for responses and start order.
module tb_spi_xfer_sched;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int TO = 15;
  localparam int L  = BW + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*BW-1:0] tx_data = '0;
  logic [N-1:0]    tx_last = '0;
  logic [N-1:0]    tx_ack, grant, rx_valid, rx_err;
  logic [BW-1:0]   rx_data, spi_d_out, spi_d_in;
  logic            spi_start, spi_busy, sched_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_start = 0;
  bit open = 1'b0;
  bit eng_dead = 1'b0;

  typedef struct {
    int         who;
    logic [7:0] d;
    bit         err;
  } exp_t;

  exp_t       sb[$];
  int         exp_st[$];
  logic [8:0] rq[N][$];

  logic          e_pend;
  logic [7:0]    e_cnt;
  logic [BW-1:0] e_sh;

  spi_xfer_sched #(
    .N_REQ(N), .BUS_WIDTH(BW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ack(tx_ack), .grant(grant),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .spi_start(spi_start), .spi_d_out(spi_d_out),
    .spi_busy(spi_busy), .spi_d_in(spi_d_in),
    .sched_busy(sched_busy)
  );

  initial forever #5 clk = ~clk;

  // engine: busy appears two cycles after start, lasts L cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_pend <= 1'b0;
      e_cnt  <= '0;
      e_sh   <= '0;
    end else begin
      e_pend <= spi_start && !eng_dead;
      if (e_pend) begin
        e_cnt <= 8'(L);
        e_sh  <= spi_d_out;
      end else if (e_cnt != 0) begin
        e_cnt <= e_cnt - 8'd1;
      end
    end
  end

  assign spi_busy = (e_cnt != 0);
  assign spi_d_in = e_sh;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = i;
        c++;
      end
    end
    return (c == 1) ? r : -1;
  endfunction

  task automatic send(input int who, input logic [7:0] d,
                      input bit last, input bit err);
    exp_t e;
    rq[who].push_back({last, d});
    e.who = who;
    e.d   = d;
    e.err = err;
    sb.push_back(e);
    exp_st.push_back(who);
  endtask

  task automatic wait_grant(input logic [N-1:0] g);
    int n = 0;
    while (grant !== g && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_grant", grant, g);
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((sb.size() != 0 || exp_st.size() != 0 ||
            sched_busy || req != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {sched_busy, grant, 8'(sb.size())}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_ack"}, tx_ack, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_err"}, rx_err, 0);
    chk({tag, "_spi_start"}, spi_start, 0);
    chk({tag, "_spi_d_out"}, spi_d_out, 0);
    chk({tag, "_sched_busy"}, sched_busy, 0);
  endtask

  // requester model: present queue head, advance after tx_ack
  initial begin
    logic [N-1:0] ack;
    forever begin
      @(negedge clk);
      ack = tx_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          req[i]             = 1'b1;
          tx_data[i*BW +: BW] = rq[i][0][7:0];
          tx_last[i]         = rq[i][0][8];
        end else begin
          req[i]             = 1'b0;
          tx_data[i*BW +: BW] = '0;
          tx_last[i]         = 1'b0;
        end
      end
    end
  end

  // monitor: start order, burst spacing, responses, latencies
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n || !sched_busy) open = 1'b0;
      if (rst_n && spi_start) begin
        chk("ack_vs_grant", tx_ack, grant);
        if (open) chk("burst_gap", cyc - last_start, L + 4);
        last_start = cyc;
        open = 1'b1;
        if (exp_st.size() == 0) chk("start_unexp", oh2i(grant), -1);
        else chk("start_owner", oh2i(grant), exp_st.pop_front());
      end
      if (rst_n && (rx_valid != 0 || rx_err != 0)) begin
        if (sb.size() == 0) begin
          chk("resp_unexp", {rx_err, rx_valid}, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_who", rx_valid | rx_err, 1 << e.who);
          chk("resp_err", rx_err != 0, e.err);
          if (e.err) begin
            chk("err_delay", cyc - last_start, TO + 2);
          end else begin
            chk("rx_data", rx_data, e.d);
            chk("rx_delay", cyc - last_start, BW + 5);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single byte
    send(0, 8'hA5, 1'b1, 1'b0);
    n = 0;
    while (!spi_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("single_dout", spi_d_out, 8'hA5);
    chk("single_grant", grant, 4'b0001);
    @(negedge clk);
    chk("dout_hold", spi_d_out, 8'hA5);
    wait_quiet("single_idle");

    // burst from 2 while 1 waits
    send(2, 8'h3C, 1'b0, 1'b0);
    send(2, 8'hC3, 1'b0, 1'b0);
    send(2, 8'h5A, 1'b1, 1'b0);
    wait_grant(4'b0100);
    send(1, 8'h77, 1'b1, 1'b0);
    wait_quiet("burst_idle");

    // fairness: pointer sits at 2 after serving 1
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        send((2 + k) % N, 8'(8'h80 + 16 * k + r), 1'b1, 1'b0);
      end
    end
    wait_quiet("fair_idle");

    // engine never goes busy
    eng_dead = 1'b1;
    send(2, 8'hEE, 1'b1, 1'b1);
    wait_quiet("timeout_idle");
    eng_dead = 1'b0;

    // unterminated burst, requester drops after byte two
    send(3, 8'h11, 1'b0, 1'b0);
    send(3, 8'h22, 1'b0, 1'b0);
    wait_grant(4'b1000);
    send(0, 8'h33, 1'b1, 1'b0);
    wait_quiet("drop_idle");

    // reset during WAIT_DONE
    send(0, 8'h44, 1'b1, 1'b0);
    n = 0;
    while (!spi_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_seen", spi_busy, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h55, 1'b1, 1'b0);
    send(1, 8'h66, 1'b1, 1'b0);
    wait_quiet("post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
